// File: rtl/ball_motion_ctrl_if.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl_if
// Bundles the control strobes, paddle/velocity inputs and the packed ball
// coordinate / game status outputs of ball_motion_ctrl.
//   master : game logic / stimulus side (drives tick, launch, pd_x, vel_*)
//   slave  : ball engine side (drives o_bx, o_by, b_active, state, lives,
//            busy, game_over)
// Ball i occupies [14i+:14] of vel_x/vel_y and [10i+:10] of o_bx/o_by.
// ---------------------------------------------------------------------------
interface ball_motion_ctrl_if #(
    parameter int BALL_NUM = 3
);
    logic                     tick;
    logic                     launch;
    logic [9:0]               pd_x;
    logic [BALL_NUM*14-1:0]   vel_x;
    logic [BALL_NUM*14-1:0]   vel_y;
    logic [BALL_NUM*10-1:0]   o_bx;
    logic [BALL_NUM*10-1:0]   o_by;
    logic [BALL_NUM-1:0]      b_active;
    logic [1:0]               state;
    logic [2:0]               lives;
    logic                     busy;
    logic                     game_over;

    modport master (
        output tick, launch, pd_x, vel_x, vel_y,
        input  o_bx, o_by, b_active, state, lives, busy, game_over
    );

    modport slave (
        input  tick, launch, pd_x, vel_x, vel_y,
        output o_bx, o_by, b_active, state, lives, busy, game_over
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
// Ball engine for the Arkanoid datapath. BALL_NUM balls are serviced
// round-robin, one per cycle, in a sweep started by a tick strobe. Each ball
// moves by a fractional accumulator (UNIT = one pixel), bounces off the
// side/top walls and the paddle, and is lost at the bottom. A small game FSM
// (INIT/WAIT/PLAY/DEAD) handles launch, lives and game over.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   bus    : ball_motion_ctrl_if.slave (tick, launch, pd_x, vel_x, vel_y in;
//            o_bx, o_by, b_active, state, lives, busy, game_over out)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
    parameter int BALL_NUM = 3,
    parameter int MAXX     = 639,
    parameter int MAXY     = 479,
    parameter int RADIUS   = 8,
    parameter int PD_Y     = 470,
    parameter int PD_HALF  = 32,
    parameter int UNIT     = 10000,
    parameter int LIVES    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    ball_motion_ctrl_if.slave     bus
);

    // Game states
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_DEAD = 2'd3;

    localparam int IDX_W = (BALL_NUM > 1) ? $clog2(BALL_NUM) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(BALL_NUM - 1);
    localparam logic [BALL_NUM-1:0] ALL_ACTIVE = {BALL_NUM{1'b1}};

    // Geometry constants in datapath widths
    localparam logic [9:0]  X_MIN   = 10'(RADIUS);
    localparam logic [9:0]  X_MAX   = 10'(MAXX - RADIUS);
    localparam logic [9:0]  X_HOME  = 10'(MAXX / 2);
    localparam logic [9:0]  Y_MIN   = 10'(RADIUS);
    localparam logic [9:0]  Y_HOME  = 10'(PD_Y - RADIUS);
    localparam logic [9:0]  Y_PAD   = 10'(PD_Y - RADIUS);
    localparam logic [9:0]  Y_LOSS  = 10'(MAXY - RADIUS);
    localparam logic [10:0] PD_SPAN = 11'(PD_HALF);
    localparam logic [13:0] V_MAX   = 14'(UNIT - 1);
    localparam logic [14:0] ACC_MOD = 15'(UNIT);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

    // Horizontal direction at reset/launch: even balls right (0), odd left (1)
    function automatic logic [BALL_NUM-1:0] dx_home_pattern();
        logic [BALL_NUM-1:0] p;
        p = '0;
        for (int i = 0; i < BALL_NUM; i++) begin
            p[i] = ((i % 2) == 1);
        end
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]          state_q,     state_d;
    logic [2:0]          lives_q,     lives_d;
    logic                game_over_q, game_over_d;
    logic                busy_q,      busy_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic                pending_q,   pending_d;
    logic [BALL_NUM-1:0] active_q;
    logic [BALL_NUM-1:0] dx_left_q;   // 1 = moving left
    logic [BALL_NUM-1:0] dy_down_q;   // 1 = moving down
    logic [9:0]          x_q    [BALL_NUM];
    logic [9:0]          y_q    [BALL_NUM];
    logic [14:0]         accx_q [BALL_NUM];
    logic [14:0]         accy_q [BALL_NUM];

    // Control decode
    logic to_dead_s;
    logic start_s;
    logic launch_go_s;

    // Service datapath for the ball selected by idx_q
    logic [9:0]  cur_x_s, cur_y_s;
    logic [14:0] cur_ax_s, cur_ay_s;
    logic        cur_left_s, cur_down_s, cur_act_s;
    logic [13:0] vraw_x_s, vraw_y_s, vx_s, vy_s;
    logic [14:0] sum_x_s, sum_y_s;
    logic        step_x_s, step_y_s;
    logic [9:0]  nx_s, ny_s;
    logic [10:0] diff_s, dist_s;
    logic [9:0]  svc_x_s, svc_y_s;
    logic [14:0] svc_ax_s, svc_ay_s;
    logic        svc_left_s, svc_down_s, svc_act_s;

    // Decode of sweep start, launch and loss-of-all-balls conditions
    always_comb begin
        to_dead_s   = (state_q == ST_PLAY) && !busy_q && (active_q == '0);
        start_s     = bus.tick && !busy_q && (state_q != ST_DEAD) && !to_dead_s;
        launch_go_s = pending_q && !busy_q && (state_q == ST_WAIT);
    end

    // Game FSM, life counting and launch latch
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (launch_go_s) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PLAY: begin
                if (to_dead_s) begin
                    state_d     = ST_DEAD;
                    lives_d     = lives_q - 3'd1;
                    game_over_d = (lives_q == 3'd1);
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_DEAD: begin
                // With no lives left the block parks here until reset
                if ((lives_q != 3'd0) && bus.tick) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Launch is only remembered while waiting; acting on it clears it
        if (launch_go_s) begin
            pending_d = 1'b0;
        end else if (bus.launch && (state_q == ST_WAIT)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Sweep sequencer: busy for BALL_NUM cycles, idx walks the balls
    always_comb begin
        busy_d = busy_q;
        idx_d  = idx_q;
        if (busy_q) begin
            if (idx_q == IDX_LAST) begin
                busy_d = 1'b0;
                idx_d  = '0;
            end else begin
                busy_d = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
            end
        end else if (start_s) begin
            busy_d = 1'b1;
            idx_d  = '0;
        end else begin
            busy_d = 1'b0;
            idx_d  = idx_q;
        end
    end

    // Motion of the ball being serviced: accumulate, step, bounce, loss
    always_comb begin
        cur_x_s    = x_q[idx_q];
        cur_y_s    = y_q[idx_q];
        cur_ax_s   = accx_q[idx_q];
        cur_ay_s   = accy_q[idx_q];
        cur_left_s = dx_left_q[idx_q];
        cur_down_s = dy_down_q[idx_q];
        cur_act_s  = active_q[idx_q];

        vraw_x_s = bus.vel_x[int'(idx_q) * 14 +: 14];
        vraw_y_s = bus.vel_y[int'(idx_q) * 14 +: 14];
        vx_s     = (vraw_x_s > V_MAX) ? V_MAX : vraw_x_s;
        vy_s     = (vraw_y_s > V_MAX) ? V_MAX : vraw_y_s;

        // Both operands stay below UNIT, so 15 bits never overflow
        sum_x_s  = cur_ax_s + {1'b0, vx_s};
        sum_y_s  = cur_ay_s + {1'b0, vy_s};
        step_x_s = (sum_x_s >= ACC_MOD);
        step_y_s = (sum_y_s >= ACC_MOD);

        if (step_x_s) begin
            nx_s = cur_left_s ? (cur_x_s - 10'd1) : (cur_x_s + 10'd1);
        end else begin
            nx_s = cur_x_s;
        end
        if (step_y_s) begin
            ny_s = cur_down_s ? (cur_y_s + 10'd1) : (cur_y_s - 10'd1);
        end else begin
            ny_s = cur_y_s;
        end

        // |new x - paddle centre| without signed arithmetic
        diff_s = {1'b0, nx_s} - {1'b0, bus.pd_x};
        dist_s = diff_s[10] ? (11'd0 - diff_s) : diff_s;

        svc_x_s    = cur_x_s;
        svc_y_s    = cur_y_s;
        svc_ax_s   = cur_ax_s;
        svc_ay_s   = cur_ay_s;
        svc_left_s = cur_left_s;
        svc_down_s = cur_down_s;
        svc_act_s  = cur_act_s;

        if (state_q == ST_WAIT) begin
            // Ball rides on the paddle, clamped inside the side walls
            if (bus.pd_x < X_MIN) begin
                svc_x_s = X_MIN;
            end else if (bus.pd_x > X_MAX) begin
                svc_x_s = X_MAX;
            end else begin
                svc_x_s = bus.pd_x;
            end
            svc_y_s  = Y_HOME;
            svc_ax_s = 15'd0;
            svc_ay_s = 15'd0;
        end else if ((state_q == ST_PLAY) && cur_act_s) begin
            svc_x_s  = nx_s;
            svc_y_s  = ny_s;
            svc_ax_s = step_x_s ? (sum_x_s - ACC_MOD) : sum_x_s;
            svc_ay_s = step_y_s ? (sum_y_s - ACC_MOD) : sum_y_s;

            if (cur_left_s) begin
                if (nx_s <= X_MIN) begin
                    svc_left_s = 1'b0;
                end else begin
                    svc_left_s = 1'b1;
                end
            end else begin
                if (nx_s >= X_MAX) begin
                    svc_left_s = 1'b1;
                end else begin
                    svc_left_s = 1'b0;
                end
            end

            if (!cur_down_s) begin
                if (ny_s <= Y_MIN) begin
                    svc_down_s = 1'b1;
                end else begin
                    svc_down_s = 1'b0;
                end
            end else if ((ny_s == Y_PAD) && (dist_s <= PD_SPAN)) begin
                // Paddle hit wins over the loss check
                svc_down_s = 1'b0;
            end else if (ny_s >= Y_LOSS) begin
                // Lost: the final position is kept and never updated again
                svc_act_s = 1'b0;
            end else begin
                svc_down_s = 1'b1;
            end
        end else begin
            svc_x_s = cur_x_s;
        end
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            lives_q     <= LIVES_INIT;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
        end
    end

    // Per-ball registers: written by the sweep or re-armed by a launch
    always_ff @(posedge clock) begin
        if (reset) begin
            active_q  <= '0;
            dx_left_q <= dx_home_pattern();
            dy_down_q <= '0;
            for (int i = 0; i < BALL_NUM; i++) begin
                x_q[i]    <= X_HOME;
                y_q[i]    <= Y_HOME;
                accx_q[i] <= 15'd0;
                accy_q[i] <= 15'd0;
            end
        end else if (launch_go_s) begin
            active_q  <= ALL_ACTIVE;
            dx_left_q <= dx_home_pattern();
            dy_down_q <= '0;
        end else if (busy_q) begin
            x_q[idx_q]       <= svc_x_s;
            y_q[idx_q]       <= svc_y_s;
            accx_q[idx_q]    <= svc_ax_s;
            accy_q[idx_q]    <= svc_ay_s;
            dx_left_q[idx_q] <= svc_left_s;
            dy_down_q[idx_q] <= svc_down_s;
            active_q[idx_q]  <= svc_act_s;
        end else begin
            active_q <= active_q;
        end
    end

    // Pack the ball registers onto the renderer buses
    for (genvar g = 0; g < BALL_NUM; g++) begin : g_pack
        assign bus.o_bx[10*g +: 10] = x_q[g];
        assign bus.o_by[10*g +: 10] = y_q[g];
    end

    assign bus.b_active  = active_q;
    assign bus.state     = state_q;
    assign bus.lives     = lives_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = game_over_q;

endmodule
